ttt_board_ctrl: RTL
===================

TTT_BOARD_CTRL -- requirements
Module: ttt_board_ctrl

Interface
REQ-001 Parameter: FIRST_PLAYER, default 0, first mover after reset/new_game (0 = X, 1 = O).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  reset is synchronous and active-high.
REQ-004 new_game  input  1  clears the board and starts a new game; win/draw tallies are kept.
REQ-005 move_valid  input  1  move request qualifier.
REQ-006 move_cell  input  4  target cell, 0..8, row-major (0 = top-left A ... 8 = bottom-right I).
REQ-007 move_ready  output  1  high only in X_TURN or O_TURN.
REQ-008 move_reject  output  1  one-cycle pulse for an illegal move request.
REQ-009 x_board  output  9  bit k = X occupies cell k.
REQ-010 o_board  output  9  bit k = O occupies cell k.
REQ-011 turn  output  1  player to move (0 = X, 1 = O); holds the last mover during CHECK and terminal states.
REQ-012 game_over  output  1  high in X_WIN, O_WIN or DRAW.
REQ-013 winner  output  2  00 none, 01 X, 10 O, 11 draw.
REQ-014 move_count  output  4  moves accepted in the current game, 0..9.
REQ-015 x_wins, o_wins, draws  output  4 each  saturating game tallies.

Function
REQ-016 States: X_TURN, O_TURN, CHECK, X_WIN, O_WIN, DRAW.
REQ-017 Accept = move_valid & move_ready & move_cell <= 8 & cell free in both boards, sampled at a rising edge.
REQ-018 On accept at edge N: the mover's board bit sets, move_count increments, and state goes to CHECK; the new bit is visible after edge N.
REQ-019 In CHECK, move_ready = 0 and win detection runs on the mover's registered board.
  - A line (rows 0-1-2, 3-4-5, 6-7-8; columns 0-3-6, 1-4-7, 2-5-8; diagonals 0-4-8, 2-4-6) that is fully set by the mover is a win.
REQ-020 At edge N+1 (leaving CHECK):
  - win -> X_WIN or O_WIN;
  - otherwise move_count == 9 -> DRAW;
  - otherwise -> the other player's TURN state.
REQ-021 A win on the ninth move SHALL be reported as a win, not a draw.
REQ-022 Entering X_WIN, O_WIN or DRAW increments x_wins, o_wins or draws respectively, exactly once; each tally saturates at 15.
REQ-023 Illegal request in a TURN state (move_valid with cell > 8 or cell occupied): move_reject = 1 for the cycle after the edge, with no change to boards, state, turn or move_count.
REQ-024 move_valid in CHECK or a terminal state SHALL be ignored (no reject, no change).
REQ-025 Terminal states hold until new_game or reset.
REQ-026 new_game at an edge, from any state:
  - boards = 0, move_count = 0, move_reject = 0;
  - state = FIRST_PLAYER's TURN state;
  - new_game has priority over a simultaneous move_valid, and that move is dropped.
REQ-027 Invariants: x_board & o_board == 0 always; popcount(x_board | o_board) == move_count.

Reset
REQ-028 reset at an edge performs the new_game actions of REQ-026 and also clears x_wins, o_wins and draws.
REQ-029 reset has priority over new_game and move_valid, including when asserted mid-CHECK.
REQ-030 Post-reset outputs:
  - move_ready = 1, move_reject = 0, game_over = 0;
  - winner = 00, turn = FIRST_PLAYER;
  - x_board = o_board = 0, move_count = 0, all tallies = 0.

Verification
REQ-031 Move sequence X0, O3, X1, O4, X2 (FIRST_PLAYER = 0) -> x_board = 0x007, winner = 01, x_wins = 1, move_ready = 0.
REQ-032 X4, then O4 -> move_reject pulses for one cycle, o_board = 0, turn = 1, move_count = 1; then O cell 9 -> reject again with no change.
REQ-033 Full draw X0 O1 X2 O4 X3 O5 X7 O6 X8 -> winner = 11, draws = 1, move_count = 9.
REQ-034 Ninth-move win X0 O1 X2 O4 X3 O5 X7 O8 X6 -> winner = 01, not draw.
REQ-035 new_game asserted with move_valid on the same edge -> boards = 0, move_count = 0, move dropped, tallies unchanged; reset mid-game -> all outputs match REQ-030.
REQ-036 Sixteen consecutive X wins -> x_wins holds at 15.

Source files
------------

// File: rtl/ttt_board_ctrl.sv
// Tic-tac-toe board controller: accepts alternating moves, detects wins and draws,
// and keeps saturating win/draw tallies across games.
module ttt_board_ctrl #(
  parameter logic FIRST_PLAYER = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       new_game,
  input  logic       move_valid,
  input  logic [3:0] move_cell,
  output logic       move_ready,
  output logic       move_reject,
  output logic [8:0] x_board,
  output logic [8:0] o_board,
  output logic       turn,
  output logic       game_over,
  output logic [1:0] winner,
  output logic [3:0] move_count,
  output logic [3:0] x_wins,
  output logic [3:0] o_wins,
  output logic [3:0] draws
);

  typedef enum logic [2:0] {X_TURN, O_TURN, CHECK, X_WIN, O_WIN, DRAW} state_t;

  localparam state_t FIRST_STATE = FIRST_PLAYER ? O_TURN : X_TURN;

  // Cell masks for the eight winning lines: three rows, three columns, two diagonals.
  localparam logic [8:0] LINE_MASK [8] = '{
    9'h007, 9'h038, 9'h1c0,
    9'h049, 9'h092, 9'h124,
    9'h111, 9'h054
  };

  state_t     state_reg;
  state_t     state_next;
  logic [8:0] cell_bit;
  logic [8:0] mover_board;
  logic [7:0] line_hit;
  logic       in_turn;
  logic       cell_ok;
  logic       accept;
  logic       illegal_req;
  logic       mover_wins;
  logic       move_ready_next;
  logic       game_over_next;
  logic [1:0] winner_next;

  assign cell_bit    = 9'd1 << move_cell;
  assign mover_board = turn ? o_board : x_board;
  assign in_turn     = (state_reg == X_TURN) || (state_reg == O_TURN);
  assign cell_ok     = (move_cell <= 4'd8) && ((x_board | o_board) & cell_bit) == 9'd0;
  assign accept      = move_valid && in_turn && cell_ok;
  assign illegal_req = move_valid && in_turn && !cell_ok;
  assign mover_wins  = |line_hit;

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_line
      assign line_hit[gi] = (mover_board & LINE_MASK[gi]) == LINE_MASK[gi];
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      X_TURN, O_TURN: if (accept) state_next = CHECK;
      CHECK: begin
        // A ninth-move win must outrank the board-full draw.
        if (mover_wins)
          state_next = turn ? O_WIN : X_WIN;
        else if (move_count == 4'd9)
          state_next = DRAW;
        else
          state_next = turn ? X_TURN : O_TURN;
      end
      default: state_next = state_reg;
    endcase
    if (reset || new_game) state_next = FIRST_STATE;
  end

  always_comb begin
    move_ready_next = (state_next == X_TURN) || (state_next == O_TURN);
    game_over_next  = (state_next == X_WIN) || (state_next == O_WIN) || (state_next == DRAW);
    case (state_next)
      X_WIN:   winner_next = 2'b01;
      O_WIN:   winner_next = 2'b10;
      DRAW:    winner_next = 2'b11;
      default: winner_next = 2'b00;
    endcase
  end

  always_ff @(posedge clk) begin
    state_reg  <= state_next;
    move_ready <= move_ready_next;
    game_over  <= game_over_next;
    winner     <= winner_next;
    if (reset) begin
      x_board     <= 9'd0;
      o_board     <= 9'd0;
      move_count  <= 4'd0;
      move_reject <= 1'b0;
      turn        <= FIRST_PLAYER;
      x_wins      <= 4'd0;
      o_wins      <= 4'd0;
      draws       <= 4'd0;
    end else if (new_game) begin
      x_board     <= 9'd0;
      o_board     <= 9'd0;
      move_count  <= 4'd0;
      move_reject <= 1'b0;
      turn        <= FIRST_PLAYER;
    end else begin
      move_reject <= illegal_req;
      if (accept) begin
        if (turn) o_board <= o_board | cell_bit;
        else      x_board <= x_board | cell_bit;
        move_count <= move_count + 4'd1;
      end
      // turn keeps the last mover until the check hands play to the opponent.
      if (state_reg == CHECK) begin
        if (state_next == X_TURN || state_next == O_TURN) turn <= ~turn;
        if (state_next == X_WIN && x_wins != 4'hF) x_wins <= x_wins + 4'd1;
        if (state_next == O_WIN && o_wins != 4'hF) o_wins <= o_wins + 4'd1;
        if (state_next == DRAW  && draws  != 4'hF) draws  <= draws + 4'd1;
      end
    end
  end

endmodule
